// File: rtl/zebra_pkg.sv
// Shared types for the zebra frame scheduler.
//   label_t       : 2-bit label stored per pixel in the label BRAM
//   sched_state_t : frame sequencer states
//   sat_inc8      : saturating 8-bit increment used by the dropped-frame counter
//   pix_label     : maps a binarised pixel to its stored label
package zebra_pkg;

    typedef enum logic [1:0] {
        LBL_BLACK   = 2'd0,
        LBL_WHITE   = 2'd1,
        LBL_VISITED = 2'd2
    } label_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LAUNCH  = 3'd3,
        ST_DETECT  = 3'd4,
        ST_RESULT  = 3'd5
    } sched_state_t;

    // Number of cycles the detector reset is held low after a watchdog abort.
    localparam logic [1:0] DET_RST_LOW_CYCLES = 2'd2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic label_t pix_label(input logic white);
        return white ? LBL_WHITE : LBL_BLACK;
    endfunction

endpackage

// File: rtl/zebra_watchdog.sv
// Detector watchdog: counts cycles while enabled and flags the last allowed
// cycle of the detection window.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : zero the counter (asserted while the detector is launched)
//   en_i       : count this cycle (asserted while the detector is running)
//   expired_o  : high in the enabled cycle whose count is TIMEOUT_CYCLES-1
module zebra_watchdog #(
    parameter int TIMEOUT_CYCLES = 4_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at the last value rather than wrapping, so a stuck enable cannot
    // make the window appear to restart.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST_CNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/zebra_frame_scheduler.sv
// Frame-level sequencer for the 2-bit label BRAM shared by the binarised pixel
// stream and the zebra crossing detector. Captures one frame into the BRAM,
// launches the detector, routes its read and mark-visited ports, watchdogs it,
// then latches and publishes the result.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run_en              1 = process frames continuously, 0 = stop after current frame
//   pix_valid/sof/white binarised pixel stream (no backpressure)
//   det_start           1-cycle detector launch pulse
//   det_rst_n           detector reset, low 2 cycles after a watchdog abort
//   det_done/crossing/stripes  detector result
//   det_rd_addr/det_rd_data    detector read port, routed to BRAM port A
//   det_mark_we/det_mark_addr  detector mark-visited port, routed to BRAM port B
//   bram_a_*            BRAM port A (read only, 1-cycle latency)
//   bram_b_*            BRAM port B (write)
//   result_*            published result, result_valid is a 1-cycle pulse
//   frames_dropped      saturating count of SOFs ignored while busy
//   busy                1 in any state except IDLE/ARMED
module zebra_frame_scheduler
    import zebra_pkg::*;
#(
    parameter  int IMG_WIDTH      = 640,
    parameter  int IMG_HEIGHT     = 480,
    parameter  int TIMEOUT_CYCLES = 4_000_000,
    localparam int NPIX           = IMG_WIDTH * IMG_HEIGHT,
    localparam int ADDR_W         = $clog2(NPIX)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_white,
    output logic              det_start,
    output logic              det_rst_n,
    input  logic              det_done,
    input  logic              det_crossing,
    input  logic [7:0]        det_stripes,
    input  logic [ADDR_W-1:0] det_rd_addr,
    output logic [1:0]        det_rd_data,
    input  logic              det_mark_we,
    input  logic [ADDR_W-1:0] det_mark_addr,
    output logic [ADDR_W-1:0] bram_a_addr,
    input  logic [1:0]        bram_a_rdata,
    output logic              bram_b_we,
    output logic [ADDR_W-1:0] bram_b_addr,
    output logic [1:0]        bram_b_wdata,
    output logic              result_valid,
    output logic              result_crossing,
    output logic [7:0]        result_stripes,
    output logic              result_timeout,
    output logic [7:0]        frames_dropped,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [7:0]        drop_q, drop_d;
    logic [1:0]        rstn_cnt_q, rstn_cnt_d;
    logic              res_crossing_q, res_crossing_d;
    logic [7:0]        res_stripes_q, res_stripes_d;
    logic              res_timeout_q, res_timeout_d;

    logic sof_px;
    logic arm_sof;
    logic cap_px;
    logic cap_last;
    logic drop_sof;
    logic in_detect;
    logic det_finish;
    logic wd_abort;
    logic wd_clear;
    logic wd_en;
    logic wd_expired;

    assign sof_px    = pix_valid & pix_sof;
    // A SOF only opens a frame while armed and still enabled.
    assign arm_sof   = (state_q == ST_ARMED) & run_en & sof_px;
    assign cap_px    = (state_q == ST_CAPTURE) & pix_valid;
    // A SOF on the would-be final pixel restarts the frame instead of ending it.
    assign cap_last  = cap_px & ~pix_sof & (pix_cnt_q == LAST_ADDR);
    assign drop_sof  = sof_px & ((state_q == ST_LAUNCH) | (state_q == ST_DETECT) |
                                 (state_q == ST_RESULT));
    assign in_detect = (state_q == ST_DETECT);
    // det_done takes priority over the watchdog in the same cycle.
    assign det_finish = in_detect & det_done;
    assign wd_abort   = in_detect & wd_expired & ~det_done;

    zebra_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (wd_clear),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run_en) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!run_en)     state_d = ST_IDLE;
                else if (sof_px) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (cap_last) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_DETECT;
            end
            ST_DETECT: begin
                if (det_done || wd_expired) state_d = ST_RESULT;
            end
            ST_RESULT: begin
                state_d = run_en ? ST_ARMED : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs and detector read-port routing
    always_comb begin
        det_start    = (state_q == ST_LAUNCH);
        result_valid = (state_q == ST_RESULT);
        busy         = (state_q != ST_IDLE) && (state_q != ST_ARMED);
        wd_clear     = (state_q == ST_LAUNCH);
        wd_en        = in_detect;
        bram_a_addr  = '0;
        det_rd_data  = 2'b00;
        if (in_detect) begin
            bram_a_addr = det_rd_addr;
            det_rd_data = bram_a_rdata;
        end
    end

    // Port-B mux: capture writes straight from the registered counter so the
    // pixel lands in the same cycle it arrives; the detector owns the port
    // only while it is running.
    always_comb begin
        bram_b_we    = 1'b0;
        bram_b_addr  = '0;
        bram_b_wdata = 2'b00;
        if (arm_sof || cap_px) begin
            bram_b_we    = 1'b1;
            bram_b_addr  = pix_sof ? '0 : pix_cnt_q;
            bram_b_wdata = pix_label(pix_white);
        end else if (in_detect) begin
            bram_b_we    = det_mark_we;
            bram_b_addr  = det_mark_addr;
            bram_b_wdata = LBL_VISITED;
        end
    end

    // Datapath next-state: pixel counter, drop counter, abort reset, result
    always_comb begin
        pix_cnt_d      = pix_cnt_q;
        drop_d         = drop_q;
        rstn_cnt_d     = rstn_cnt_q;
        res_crossing_d = res_crossing_q;
        res_stripes_d  = res_stripes_q;
        res_timeout_d  = res_timeout_q;

        // The SOF pixel itself occupies addr 0, so the counter resumes at 1.
        if (arm_sof) begin
            pix_cnt_d = ADDR_W'(1);
        end else if (cap_px) begin
            if (pix_sof)        pix_cnt_d = ADDR_W'(1);
            else if (cap_last)  pix_cnt_d = '0;
            else                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        end

        if (drop_sof) drop_d = sat_inc8(drop_q);

        if (wd_abort)                rstn_cnt_d = DET_RST_LOW_CYCLES;
        else if (rstn_cnt_q != 2'd0) rstn_cnt_d = rstn_cnt_q - 2'd1;

        // Result fields change on the same edge that raises result_valid and
        // then hold until the next result.
        if (det_finish) begin
            res_crossing_d = det_crossing;
            res_stripes_d  = det_stripes;
            res_timeout_d  = 1'b0;
        end else if (wd_abort) begin
            res_crossing_d = 1'b0;
            res_stripes_d  = 8'd0;
            res_timeout_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q      <= '0;
            drop_q         <= 8'd0;
            rstn_cnt_q     <= 2'd0;
            res_crossing_q <= 1'b0;
            res_stripes_q  <= 8'd0;
            res_timeout_q  <= 1'b0;
        end else begin
            pix_cnt_q      <= pix_cnt_d;
            drop_q         <= drop_d;
            rstn_cnt_q     <= rstn_cnt_d;
            res_crossing_q <= res_crossing_d;
            res_stripes_q  <= res_stripes_d;
            res_timeout_q  <= res_timeout_d;
        end
    end

    assign det_rst_n       = (rstn_cnt_q == 2'd0);
    assign result_crossing = res_crossing_q;
    assign result_stripes  = res_stripes_q;
    assign result_timeout  = res_timeout_q;
    assign frames_dropped  = drop_q;

endmodule

// File: tb/tb_zebra_frame_scheduler.sv
// Self-checking bench for zebra_frame_scheduler on a 4x4 frame with a
// 100-cycle watchdog. Expected port-B writes are queued as stimulus is driven
// and popped by a monitor whenever the DUT writes.
module tb_zebra_frame_scheduler;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int TO = 100;
    localparam int NP = W * H;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          run_en;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_white;
    logic          det_start;
    logic          det_rst_n;
    logic          det_done;
    logic          det_crossing;
    logic [7:0]    det_stripes;
    logic [AW-1:0] det_rd_addr;
    logic [1:0]    det_rd_data;
    logic          det_mark_we;
    logic [AW-1:0] det_mark_addr;
    logic [AW-1:0] bram_a_addr;
    logic [1:0]    bram_a_rdata;
    logic          bram_b_we;
    logic [AW-1:0] bram_b_addr;
    logic [1:0]    bram_b_wdata;
    logic          result_valid;
    logic          result_crossing;
    logic [7:0]    result_stripes;
    logic          result_timeout;
    logic [7:0]    frames_dropped;
    logic          busy;

    int tot = 0;
    int bad = 0;
    int exp_drop = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [1:0] mem [NP];

    always #5 clk = ~clk;

    zebra_frame_scheduler #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_white(pix_white),
        .det_start(det_start), .det_rst_n(det_rst_n),
        .det_done(det_done), .det_crossing(det_crossing), .det_stripes(det_stripes),
        .det_rd_addr(det_rd_addr), .det_rd_data(det_rd_data),
        .det_mark_we(det_mark_we), .det_mark_addr(det_mark_addr),
        .bram_a_addr(bram_a_addr), .bram_a_rdata(bram_a_rdata),
        .bram_b_we(bram_b_we), .bram_b_addr(bram_b_addr), .bram_b_wdata(bram_b_wdata),
        .result_valid(result_valid), .result_crossing(result_crossing),
        .result_stripes(result_stripes), .result_timeout(result_timeout),
        .frames_dropped(frames_dropped), .busy(busy)
    );

    // Dual-port label BRAM model, 1-cycle read latency on port A.
    always @(posedge clk) begin
        if (bram_b_we === 1'b1) mem[bram_b_addr] <= bram_b_wdata;
        bram_a_rdata <= mem[bram_a_addr];
    end

    // Port-B scoreboard monitor.
    always @(negedge clk) begin
        #2;
        if (bram_b_we === 1'b1) begin
            tot++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL portb_unexpected got addr=%0d data=%0d, want no write", bram_b_addr, bram_b_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bram_b_addr !== mon_e.addr || bram_b_wdata !== mon_e.data) begin
                    bad++;
                    $display("FAIL portb_write got addr=%0d data=%0d, want addr=%0d data=%0d",
                             bram_b_addr, bram_b_wdata, mon_e.addr, mon_e.data);
                end
            end
        end else if (bram_b_we !== 1'b0) begin
            tot++;
            bad++;
            $display("FAIL portb_we got %b want 0/1", bram_b_we);
        end
    end

    task automatic idle_inputs();
        pix_valid     = 1'b0;
        pix_sof       = 1'b0;
        pix_white     = 1'b0;
        det_done      = 1'b0;
        det_crossing  = 1'b0;
        det_stripes   = 8'd0;
        det_rd_addr   = '0;
        det_mark_we   = 1'b0;
        det_mark_addr = '0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle_inputs();
    endtask

    // Drives a full frame; pixel i is white when (i odd) xor inv.
    task automatic capture_frame(input logic inv);
        for (int i = 0; i < NP; i++) begin
            logic w;
            wr_t  e;
            next_cycle();
            w = (i % 2 == 1) ^ inv;
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_white = w;
            e.addr = AW'(i);
            e.data = {1'b0, w};
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        run_en = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        tot++; if (det_start !== 1'b0) begin bad++; $display("FAIL rst_det_start got=%b want=0", det_start); end
        tot++; if (det_rst_n !== 1'b1) begin bad++; $display("FAIL rst_det_rst_n got=%b want=1", det_rst_n); end
        tot++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid got=%b want=0", result_valid); end
        tot++; if ({result_crossing, result_stripes, result_timeout} !== 10'd0) begin
            bad++; $display("FAIL rst_result_fields got=%b/%0d/%b want=0/0/0", result_crossing, result_stripes, result_timeout);
        end
        tot++; if (frames_dropped !== 8'd0) begin bad++; $display("FAIL rst_dropped got=%0d want=0", frames_dropped); end
        tot++; if (bram_a_addr !== '0 || det_rd_data !== 2'b00) begin
            bad++; $display("FAIL rst_porta got addr=%0d rd=%0d want 0/0", bram_a_addr, det_rd_data);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        #1;
        tot++; if (bram_b_we !== 1'b0) begin bad++; $display("FAIL idle_sof_write got we=%b want=0", bram_b_we); end
        next_cycle();
        #1;
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_sof_busy got=%b want=0", busy); end
    endtask

    task automatic test_capture_detect();
        int   starts = 0;
        int   early_rv = 0;
        int   a;
        logic [1:0] ev;
        wr_t  e;
        next_cycle();
        run_en = 1'b1;
        next_cycle();
        #1;
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL armed_busy got=%b want=0", busy); end
        capture_frame(1'b0);
        next_cycle();
        #1;
        if (det_start === 1'b1) starts++;
        tot++; if (busy !== 1'b1) begin bad++; $display("FAIL launch_busy got=%b want=1", busy); end
        for (int d = 0; d < 50; d++) begin
            next_cycle();
            if (d < NP) det_rd_addr = AW'(d);
            if (d == 20) begin
                det_mark_we   = 1'b1;
                det_mark_addr = 4'd7;
                e.addr = 4'd7;
                e.data = 2'b10;
                exp_q.push_back(e);
            end
            if (d == 21) det_rd_addr = 4'd7;
            if (d == 49) begin
                det_done     = 1'b1;
                det_crossing = 1'b1;
                det_stripes  = 8'd4;
            end
            #1;
            if (det_start === 1'b1) starts++;
            if (result_valid !== 1'b0) early_rv++;
            if (d >= 1 && d <= NP) begin
                a  = d - 1;
                ev = {1'b0, a[0]};
                tot++; if (det_rd_data !== ev) begin
                    bad++; $display("FAIL detect_read addr=%0d got=%0d want=%0d", a, det_rd_data, ev);
                end
            end
            if (d == 5) begin
                tot++; if (bram_a_addr !== 4'd5) begin bad++; $display("FAIL porta_route got=%0d want=5", bram_a_addr); end
            end
            if (d == 20) begin
                tot++; if ({bram_b_we, bram_b_addr, bram_b_wdata} !== {1'b1, 4'd7, 2'b10}) begin
                    bad++; $display("FAIL mark_route got we=%b addr=%0d wd=%0d want 1/7/2", bram_b_we, bram_b_addr, bram_b_wdata);
                end
            end
            if (d == 22) begin
                tot++; if (det_rd_data !== 2'b10) begin bad++; $display("FAIL mark_readback got=%0d want=2", det_rd_data); end
            end
        end
        next_cycle();
        #1;
        tot++; if (early_rv !== 0) begin bad++; $display("FAIL early_result got=%0d cycles want=0", early_rv); end
        tot++; if (result_valid !== 1'b1) begin bad++; $display("FAIL done_valid got=%b want=1", result_valid); end
        tot++; if ({result_crossing, result_stripes, result_timeout} !== {1'b1, 8'd4, 1'b0}) begin
            bad++; $display("FAIL done_fields got=%b/%0d/%b want=1/4/0", result_crossing, result_stripes, result_timeout);
        end
        tot++; if (starts !== 1) begin bad++; $display("FAIL det_start_count got=%0d want=1", starts); end
        next_cycle();
        #1;
        tot++; if (result_valid !== 1'b0 || result_stripes !== 8'd4 || busy !== 1'b0) begin
            bad++; $display("FAIL after_result got rv=%b st=%0d busy=%b want 0/4/0", result_valid, result_stripes, busy);
        end
    endtask

    task automatic test_timeout();
        int res_at = -1;
        int low_cnt = 0;
        int low_first = -1;
        int pulses = 0;
        logic rc = 1'b1;
        logic rt = 1'b0;
        logic [7:0] rs = 8'hFF;
        capture_frame(1'b1);
        next_cycle();
        #1;
        tot++; if (det_start !== 1'b1 || result_stripes !== 8'd4) begin
            bad++; $display("FAIL to_launch got start=%b st=%0d want 1/4", det_start, result_stripes);
        end
        for (int k = 0; k < TO + 6; k++) begin
            next_cycle();
            det_crossing = 1'b1;
            det_stripes  = 8'd9;
            #1;
            if (result_valid === 1'b1) begin
                pulses++;
                if (res_at < 0) begin
                    res_at = k;
                    rc = result_crossing;
                    rs = result_stripes;
                    rt = result_timeout;
                end
            end
            if (det_rst_n !== 1'b1) begin
                low_cnt++;
                if (low_first < 0) low_first = k;
            end
        end
        tot++; if (res_at !== TO) begin bad++; $display("FAIL to_cycle got=%0d want=%0d", res_at, TO); end
        tot++; if (pulses !== 1) begin bad++; $display("FAIL to_pulses got=%0d want=1", pulses); end
        tot++; if ({rc, rs, rt} !== {1'b0, 8'd0, 1'b1}) begin
            bad++; $display("FAIL to_fields got=%b/%0d/%b want=0/0/1", rc, rs, rt);
        end
        tot++; if (low_cnt !== 2 || low_first !== TO) begin
            bad++; $display("FAIL to_det_rst_n got low=%0d first=%0d want 2/%0d", low_cnt, low_first, TO);
        end
        next_cycle();
        det_done     = 1'b1;
        det_crossing = 1'b1;
        det_stripes  = 8'd5;
        next_cycle();
        #1;
        tot++; if (result_valid !== 1'b0 || result_timeout !== 1'b1 || result_stripes !== 8'd0) begin
            bad++; $display("FAIL done_outside_detect got rv=%b to=%b st=%0d want 0/1/0", result_valid, result_timeout, result_stripes);
        end
    endtask

    task automatic test_done_at_deadline();
        int low_cnt = 0;
        capture_frame(1'b0);
        next_cycle();
        for (int d = 0; d < TO; d++) begin
            next_cycle();
            if (d == TO - 1) begin
                det_done     = 1'b1;
                det_crossing = 1'b1;
                det_stripes  = 8'd7;
            end
            #1;
            if (det_rst_n !== 1'b1) low_cnt++;
        end
        next_cycle();
        #1;
        if (det_rst_n !== 1'b1) low_cnt++;
        tot++; if (result_valid !== 1'b1) begin bad++; $display("FAIL deadline_valid got=%b want=1", result_valid); end
        tot++; if ({result_crossing, result_stripes, result_timeout} !== {1'b1, 8'd7, 1'b0}) begin
            bad++; $display("FAIL deadline_fields got=%b/%0d/%b want=1/7/0", result_crossing, result_stripes, result_timeout);
        end
        tot++; if (low_cnt !== 0) begin bad++; $display("FAIL deadline_det_rst_n got low=%0d want=0", low_cnt); end
    endtask

    task automatic test_sof_restart();
        for (int n = 0; n < 25; n++) begin
            logic [AW-1:0] ad;
            wr_t e;
            next_cycle();
            ad = (n < 9) ? AW'(n) : AW'(n - 9);
            pix_valid = 1'b1;
            pix_sof   = (n == 0) || (n == 9);
            pix_white = ~ad[0];
            e.addr = ad;
            e.data = {1'b0, ~ad[0]};
            exp_q.push_back(e);
            #1;
            if (n == 10) begin
                tot++; if (bram_b_addr !== 4'd1) begin bad++; $display("FAIL restart_addr got=%0d want=1", bram_b_addr); end
            end
            if (n == 16) begin
                tot++; if (det_start !== 1'b0 || busy !== 1'b1) begin
                    bad++; $display("FAIL restart_no_early_launch got start=%b busy=%b want 0/1", det_start, busy);
                end
            end
        end
        next_cycle();
        #1;
        tot++; if (det_start !== 1'b1) begin bad++; $display("FAIL restart_launch got=%b want=1", det_start); end
        for (int d = 0; d < 4; d++) begin
            next_cycle();
            if (d == 3) begin
                det_done    = 1'b1;
                det_stripes = 8'd3;
            end
        end
        next_cycle();
        #1;
        tot++; if (result_valid !== 1'b1 || result_stripes !== 8'd3) begin
            bad++; $display("FAIL restart_result got rv=%b st=%0d want 1/3", result_valid, result_stripes);
        end
        tot++; if (frames_dropped !== 8'(exp_drop)) begin
            bad++; $display("FAIL restart_not_dropped got=%0d want=%0d", frames_dropped, exp_drop);
        end
    endtask

    task automatic test_drop_saturate();
        for (int f = 0; f < 3; f++) begin
            capture_frame(1'b0);
            next_cycle();
            pix_valid = 1'b1;
            pix_sof   = 1'b1;
            if (exp_drop < 255) exp_drop++;
            for (int d = 0; d < TO - 1; d++) begin
                next_cycle();
                pix_valid = 1'b1;
                pix_sof   = 1'b1;
                pix_white = 1'b1;
                if (exp_drop < 255) exp_drop++;
                if (d == TO - 2) begin
                    det_done    = 1'b1;
                    det_stripes = 8'd2;
                end
            end
            next_cycle();
            #1;
            tot++; if (result_valid !== 1'b1 || result_timeout !== 1'b0) begin
                bad++; $display("FAIL drop_result frame=%0d got rv=%b to=%b want 1/0", f, result_valid, result_timeout);
            end
            tot++; if (frames_dropped !== 8'(exp_drop)) begin
                bad++; $display("FAIL drop_count frame=%0d got=%0d want=%0d", f, frames_dropped, exp_drop);
            end
        end
    endtask

    task automatic test_run_en_drop();
        int pulses = 0;
        int starts = 0;
        for (int i = 0; i < NP; i++) begin
            wr_t e;
            next_cycle();
            pix_valid = 1'b1;
            pix_sof   = (i == 0);
            pix_white = 1'b1;
            if (i == 3) run_en = 1'b0;
            e.addr = AW'(i);
            e.data = 2'b01;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (k == 10) det_done = 1'b1;
            #1;
            if (det_start === 1'b1) starts++;
            if (result_valid === 1'b1) pulses++;
        end
        tot++; if (starts !== 1) begin bad++; $display("FAIL runen_launch got=%0d want=1", starts); end
        tot++; if (pulses !== 1) begin bad++; $display("FAIL runen_pulses got=%0d want=1", pulses); end
        tot++; if (busy !== 1'b0) begin bad++; $display("FAIL runen_idle_busy got=%b want=0", busy); end
        next_cycle();
        pix_valid = 1'b1;
        pix_sof   = 1'b1;
        #1;
        tot++; if (bram_b_we !== 1'b0) begin bad++; $display("FAIL runen_sof_write got we=%b want=0", bram_b_we); end
        repeat (2) next_cycle();
        #1;
        tot++; if (busy !== 1'b0 || det_start !== 1'b0) begin
            bad++; $display("FAIL runen_sof_ignored got busy=%b start=%b want 0/0", busy, det_start);
        end
    endtask

    initial begin
        for (int i = 0; i < NP; i++) mem[i] = 2'b11;
        test_reset();
        test_capture_detect();
        test_timeout();
        test_done_at_deadline();
        test_sof_restart();
        test_drop_saturate();
        test_run_en_drop();
        repeat (3) next_cycle();
        tot++; if (exp_q.size() !== 0) begin
            bad++; $display("FAIL portb_missing got %0d writes outstanding want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
